// File: rtl/if_layer_weight_loader.sv
// Bulk loader for one layer's weight memory: streams weights in neuron-major order,
// optionally reads them back to compare XOR checksums, and serves single host accesses when idle.
module if_layer_weight_loader #(
    parameter int unsigned WEIGHT_SIZE       = 32,
    parameter int unsigned NUM_INPUTS        = 4,
    parameter int unsigned NUM_NEURONS       = 1,
    parameter int unsigned LAYER_ADDR_WIDTH  = 28,
    parameter int unsigned WEIGHT_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        verify,
    input  logic [WEIGHT_SIZE-1:0]      w_data,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [LAYER_ADDR_WIDTH-1:0] host_addr,
    input  logic [WEIGHT_SIZE-1:0]      host_din,
    input  logic                        host_wen,
    input  logic                        host_ren,
    output logic [WEIGHT_SIZE-1:0]      host_dout,
    output logic                        host_ack,
    output logic [LAYER_ADDR_WIDTH-1:0] mem_addr,
    output logic [WEIGHT_SIZE-1:0]      mem_din,
    output logic                        mem_wen,
    input  logic [WEIGHT_SIZE-1:0]      mem_dout,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned NeurW = 4;
    localparam int unsigned PadW  = LAYER_ADDR_WIDTH - WEIGHT_ADDR_WIDTH - NeurW;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StVerify,
        StCheck,
        StHost
    } state_e;

    state_e                       state_q, state_d;
    logic [NeurW-1:0]             neuron_idx_q, neuron_idx_d;
    logic [WEIGHT_ADDR_WIDTH-1:0] input_idx_q, input_idx_d;
    logic [WEIGHT_SIZE-1:0]       wr_sum_q, wr_sum_d;
    logic [WEIGHT_SIZE-1:0]       rd_sum_q, rd_sum_d;
    logic                         verify_q, verify_d;
    logic                         rd_vld_q, rd_vld_d;
    logic                         issue_done_q, issue_done_d;
    logic                         host_wr_q, host_wr_d;
    logic [WEIGHT_SIZE-1:0]       host_dout_q, host_dout_d;
    logic                         host_ack_q, host_ack_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic last_in, last_neu, host_go;

    assign last_in  = (input_idx_q == WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1));
    assign last_neu = (neuron_idx_q == NeurW'(NUM_NEURONS - 1));

    // The ack cycle is masked so a host still holding its strobe is not served twice.
    assign host_go = rst & ~start & (host_wen | host_ren) & ~host_ack_q;

    assign busy      = (state_q == StLoad) || (state_q == StVerify) || (state_q == StCheck);
    assign host_dout = host_dout_q;
    assign host_ack  = host_ack_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        mem_addr = {{PadW{1'b0}}, neuron_idx_q, input_idx_q};
        mem_din  = '0;
        mem_wen  = 1'b0;
        w_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (host_go) begin
                    mem_addr = host_addr;
                    mem_din  = host_din;
                    mem_wen  = host_wen;
                end
            end
            StLoad: begin
                w_ready = 1'b1;
                mem_wen = w_valid;
                mem_din = w_data;
            end
            StHost:  mem_addr = host_addr;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        neuron_idx_d = neuron_idx_q;
        input_idx_d  = input_idx_q;
        wr_sum_d     = wr_sum_q;
        rd_sum_d     = rd_sum_q;
        verify_d     = verify_q;
        rd_vld_d     = rd_vld_q;
        issue_done_d = issue_done_q;
        host_wr_d    = host_wr_q;
        host_dout_d  = host_dout_q;
        host_ack_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neuron_idx_d = '0;
                    input_idx_d  = '0;
                    wr_sum_d     = '0;
                    rd_sum_d     = '0;
                    err_d        = 1'b0;
                    verify_d     = verify;
                    rd_vld_d     = 1'b0;
                    issue_done_d = 1'b0;
                    state_d      = StLoad;
                end else if (host_go) begin
                    host_wr_d = host_wen;
                    state_d   = StHost;
                end
            end
            StLoad: begin
                if (w_valid) begin
                    wr_sum_d = wr_sum_q ^ w_data;
                    if (last_in) begin
                        input_idx_d = '0;
                        if (last_neu) begin
                            neuron_idx_d = '0;
                            rd_vld_d     = 1'b0;
                            issue_done_d = 1'b0;
                            state_d      = verify_q ? StVerify : StCheck;
                        end else begin
                            neuron_idx_d = neuron_idx_q + 1'b1;
                        end
                    end else begin
                        input_idx_d = input_idx_q + 1'b1;
                    end
                end
            end
            StVerify: begin
                // Read data trails its address by one cycle, so folding lags issue.
                if (rd_vld_q) begin
                    rd_sum_d = rd_sum_q ^ mem_dout;
                end
                if (issue_done_q) begin
                    rd_vld_d = 1'b0;
                    state_d  = StCheck;
                end else begin
                    rd_vld_d = 1'b1;
                    if (last_in) begin
                        input_idx_d = '0;
                        if (last_neu) begin
                            neuron_idx_d = '0;
                            issue_done_d = 1'b1;
                        end else begin
                            neuron_idx_d = neuron_idx_q + 1'b1;
                        end
                    end else begin
                        input_idx_d = input_idx_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                err_d   = verify_q && (wr_sum_q != rd_sum_q);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StHost: begin
                if (!host_wr_q) begin
                    host_dout_d = mem_dout;
                end
                host_ack_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            neuron_idx_q <= '0;
            input_idx_q  <= '0;
            wr_sum_q     <= '0;
            rd_sum_q     <= '0;
            verify_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            issue_done_q <= 1'b0;
            host_wr_q    <= 1'b0;
            host_dout_q  <= '0;
            host_ack_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            neuron_idx_q <= neuron_idx_d;
            input_idx_q  <= input_idx_d;
            wr_sum_q     <= wr_sum_d;
            rd_sum_q     <= rd_sum_d;
            verify_q     <= verify_d;
            rd_vld_q     <= rd_vld_d;
            issue_done_q <= issue_done_d;
            host_wr_q    <= host_wr_d;
            host_dout_q  <= host_dout_d;
            host_ack_q   <= host_ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_if_layer_weight_loader.sv
// Scoreboard bench for if_layer_weight_loader: two neurons of four weights, a behavioural
// weight memory with optional read corruption, and queues of expected writes/reads/acks/done.
module tb_if_layer_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        verify;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [27:0] host_addr;
    logic [31:0] host_din;
    logic        host_wen;
    logic        host_ren;
    logic [31:0] host_dout;
    logic        host_ack;
    logic [27:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout = '0;
    logic        busy;
    logic        done;
    logic        err;

    if_layer_weight_loader #(
        .WEIGHT_SIZE      (32),
        .NUM_INPUTS       (4),
        .NUM_NEURONS      (2),
        .LAYER_ADDR_WIDTH (28),
        .WEIGHT_ADDR_WIDTH(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .verify   (verify),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .host_addr(host_addr),
        .host_din (host_din),
        .host_wen (host_wen),
        .host_ren (host_ren),
        .host_dout(host_dout),
        .host_ack (host_ack),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wen  (mem_wen),
        .mem_dout (mem_dout),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [27:0] rd_q[$];
    logic        done_q[$];
    logic [31:0] hd_q[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_load_wr = 0;
    bit          corrupt = 1'b0;
    logic [31:0] last_rd = '0;
    logic [31:0] mem_m[logic [27:0]];
    wr_t         mon_e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] addr_of(input int n, input int i);
        return 28'((n << 10) | i);
    endfunction

    always @(posedge clk) cyc++;

    // Weight memory: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
        if (corrupt && mem_addr == 28'h0000402) rd = rd ^ 32'h100;
        mem_dout <= rd;
        if (mem_wen) mem_m[mem_addr] = mem_din;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (mem_wen) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 1, 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    check_eq("wr_addr", mem_addr, mon_e.addr);
                    check_eq("wr_data", mem_din, mon_e.data);
                end
                if (w_ready) last_load_wr = cyc;
            end
            if (busy && !w_ready && rd_q.size() > 0) begin
                check_eq("rd_addr", mem_addr, rd_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
                else check_eq("err_at_done", err, done_q.pop_front());
            end
            if (host_ack) begin
                if (hd_q.size() == 0) check_eq("ack_unexpected", 1, 0);
                else check_eq("host_dout", host_dout, hd_q.pop_front());
            end
        end
    end

    task automatic push_load(input bit vfy, input bit exp_err);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 4; i++) begin
                wr_q.push_back('{addr: addr_of(n, i), data: 32'(n * 4 + i + 1)});
                if (vfy) rd_q.push_back(addr_of(n, i));
            end
        end
        done_q.push_back(exp_err);
    endtask

    task automatic pulse_start(input bit vfy, input bit with_host, input logic [27:0] ha,
                               input logic [31:0] hd);
        @(posedge clk); #1;
        start  = 1'b1;
        verify = vfy;
        if (with_host) begin
            host_wen  = 1'b1;
            host_addr = ha;
            host_din  = hd;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("err_cleared", err, 0);
    endtask

    task automatic drive_words(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                @(posedge clk); #1;
            end
            w_valid = 1'b1;
            w_data  = 32'(k + 1);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic wait_done(input bit chk_lat);
        bit got = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("done_seen", got, 1);
        if (chk_lat) check_eq("done_latency", cyc - last_load_wr, 2);
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("ack_seen", got, 1);
        #1;
        host_wen = 1'b0;
        host_ren = 1'b0;
    endtask

    task automatic host_read(input logic [27:0] a, input logic [31:0] exp);
        hd_q.push_back(exp);
        last_rd = exp;
        @(posedge clk); #1;
        host_ren  = 1'b1;
        host_addr = a;
        wait_ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; verify = 1'b0; w_data = '0; w_valid = 1'b0;
        host_addr = '0; host_din = '0; host_wen = 1'b0; host_ren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ack", host_ack, 0);
        check_eq("rst_wready", w_ready, 0);
        check_eq("rst_wen", mem_wen, 0);
        check_eq("rst_hdout", host_dout, 0);
        rst = 1'b1;

        // Plain load without readback.
        push_load(1'b0, 1'b0);
        pulse_start(1'b0, 1'b0, '0, '0);
        drive_words(8);
        wait_done(1'b1);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("idle_busy", busy, 0);

        // Load with echoing readback.
        push_load(1'b1, 1'b0);
        pulse_start(1'b1, 1'b0, '0, '0);
        drive_words(8);
        wait_done(1'b0);

        host_read(28'h0000401, 32'd6);

        // Corrupted readback word raises err until the next start.
        corrupt = 1'b1;
        push_load(1'b1, 1'b1);
        pulse_start(1'b1, 1'b0, '0, '0);
        drive_words(8);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        check_eq("err_hold", err, 1);
        corrupt = 1'b0;

        // start and host write together: load first, host write in the done cycle.
        push_load(1'b0, 1'b0);
        wr_q.push_back('{addr: 28'h0000001, data: 32'hABCD});
        hd_q.push_back(last_rd);
        pulse_start(1'b0, 1'b1, 28'h0000001, 32'hABCD);
        drive_words(8);
        wait_done(1'b1);
        check_eq("host_wr_at_done", mem_wen, 1);
        check_eq("host_wr_addr", mem_addr, 28'h0000001);
        wait_ack();
        host_read(28'h0000001, 32'hABCD);

        // Reset in the middle of a load, then a fresh load from address 0.
        push_load(1'b0, 1'b0);
        pulse_start(1'b0, 1'b0, '0, '0);
        drive_words(3);
        w_valid = 1'b1;
        w_data  = 32'd4;
        #1;
        check_eq("pre_rst_wen", mem_wen, 1);
        rst = 1'b0;
        #1;
        check_eq("async_wen", mem_wen, 0);
        check_eq("async_wready", w_ready, 0);
        check_eq("async_busy", busy, 0);
        w_valid = 1'b0;
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        push_load(1'b1, 1'b0);
        pulse_start(1'b1, 1'b0, '0, '0);
        drive_words(8);
        wait_done(1'b0);

        repeat (4) @(negedge clk);
        check_eq("wr_q_empty", wr_q.size(), 0);
        check_eq("rd_q_empty", rd_q.size(), 0);
        check_eq("done_q_empty", done_q.size(), 0);
        check_eq("hd_q_empty", hd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_layer_weight_loader.md
IF_LAYER_WEIGHT_LOADER -- requirements
Module: if_layer_weight_loader

Interface
REQ-001 SHALL have parameter WEIGHT_SIZE, default 32: weight word width.
REQ-002 SHALL have parameter NUM_INPUTS, default 4: weights per neuron.
REQ-003 SHALL have parameter NUM_NEURONS, default 1: neurons in the layer (≤16).
REQ-004 SHALL have parameter LAYER_ADDR_WIDTH, default 28: layer memory address width.
REQ-005 SHALL have parameter WEIGHT_ADDR_WIDTH, default 10: per-neuron weight address width.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a bulk load.
REQ-009 SHALL have port verify  in  1  sampled with start; 1 = readback verify after load.
REQ-010 SHALL have port w_data  in  WEIGHT_SIZE  weight stream data, neuron-major order.
REQ-011 SHALL have ports w_valid  in  1  and w_ready  out  1  forming the weight stream handshake.
REQ-012 SHALL have ports host_addr  in  LAYER_ADDR_WIDTH, host_din  in  WEIGHT_SIZE, host_wen  in  1, host_ren  in  1  for single host accesses.
REQ-013 SHALL have ports host_dout  out  WEIGHT_SIZE  and host_ack  out  1  returning host access results.
REQ-014 SHALL have ports mem_addr  out  LAYER_ADDR_WIDTH, mem_din  out  WEIGHT_SIZE, mem_wen  out  1, mem_dout  in  WEIGHT_SIZE  driving the layer weight port.
REQ-015 SHALL have ports busy  out  1, done  out  1, err  out  1.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, VERIFY, CHECK, HOST.
REQ-017 SHALL form mem_addr as {zero-extended neuron_idx in bits [LAYER_ADDR_WIDTH-1:WEIGHT_ADDR_WIDTH], input_idx in bits [WEIGHT_ADDR_WIDTH-1:0]}.
REQ-018 SHALL leave IDLE on start=1 by clearing both indices, the checksum and err, latching verify, and entering LOAD.
REQ-019 SHALL, in IDLE with start=0 and host_wen or host_ren set, enter HOST and drive mem_addr=host_addr and mem_din=host_din; host_wen wins when both strobes are set.
REQ-020 SHALL, when start and a host strobe coincide, give priority to start; host_ack SHALL stay 0 and the host SHALL hold its request until served in IDLE.
REQ-021 SHALL assert mem_wen combinationally with host_wen in the IDLE→HOST cycle, and never otherwise outside LOAD.
REQ-022 SHALL, in HOST, register host_dout<=mem_dout (read; unchanged on write), pulse host_ack for 1 cycle, and return to IDLE.
REQ-023 SHALL assert w_ready=1 only in LOAD; in LOAD, mem_wen=w_valid and mem_din=w_data.
REQ-024 SHALL, on each LOAD handshake, XOR w_data into the checksum and advance input_idx, wrapping at NUM_INPUTS-1 to 0 while incrementing neuron_idx.
REQ-025 SHALL, on the handshake at neuron_idx=NUM_NEURONS-1, input_idx=NUM_INPUTS-1, enter VERIFY (latched verify=1) or CHECK without comparison (verify=0), with indices cleared.
REQ-026 SHALL, in VERIFY, issue one read address per cycle over all NUM_NEURONS*NUM_INPUTS addresses; mem_dout is valid 1 cycle after its address.
REQ-027 SHALL XOR each returned word into a readback checksum one cycle after its address, and enter CHECK once the last word is folded.
REQ-028 SHALL, in CHECK, set err=1 if verify was latched and the checksums differ, pulse done for 1 cycle, and return to IDLE.
REQ-029 SHALL hold err until the next accepted start or reset.
REQ-030 SHALL drive busy=1 in LOAD, VERIFY and CHECK, and busy=0 otherwise.
REQ-031 SHALL ignore start while not in IDLE.
REQ-032 SHALL not time out on a w_valid stall in LOAD; the FSM SHALL wait indefinitely.

Reset
REQ-033 SHALL, while rst=0, go to IDLE immediately and zero both indices, both checksums, host_dout, host_ack, done, err, busy, w_ready and mem_wen, regardless of the current state.

Verification
REQ-034 SHALL cover: NUM_NEURONS=2, NUM_INPUTS=4, verify=0, weights 1..8 → mem_addr 0x0000000-0x0000003 then 0x0000400-0x0000403, done pulse after 8th write, err=0.
REQ-035 SHALL cover: same load with verify=1 and memory model echoing writes → 8 read addresses, checksum 0x8 matched, done, err=0.
REQ-036 SHALL cover: verify=1 with the model corrupting word at 0x0000402 → err=1 after done; err=0 again after the next start.
REQ-037 SHALL cover: host_ren at addr 0x0000401 in IDLE → host_ack on the following cycle with host_dout = stored weight 6.
REQ-038 SHALL cover: start and host_wen in the same cycle → load runs first, host write issued on the first IDLE cycle after done.
REQ-039 SHALL cover: rst=0 asserted mid-LOAD after 3 writes → mem_wen, w_ready and busy fall asynchronously; a fresh start restarts at address 0.
